// File: rtl/alarm_tone_ctrl.sv
// Alarm sequencer: threshold/hysteresis flags on DHT11 readings, mute latch,
// and an on/off buzzer cadence with a tone divider latched at each tone-on entry.
module alarm_tone_ctrl #(
    parameter logic [7:0]  TEMP_HI   = 8'd30,
    parameter logic [7:0]  TEMP_HYST = 8'd2,
    parameter logic [7:0]  HUMI_HI   = 8'd80,
    parameter logic [7:0]  HUMI_HYST = 8'd5,
    parameter logic [24:0] TIME_ON   = 25'd24999999,
    parameter logic [24:0] TIME_OFF  = 25'd24999999,
    parameter logic [17:0] TONE_TEMP = 18'd113635,
    parameter logic [17:0] TONE_HUMI = 18'd151514
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        data_valid,
    input  logic        checksum_ok,
    input  logic [7:0]  temp_int,
    input  logic [7:0]  humi_int,
    input  logic        mute,
    output logic        alarm,
    output logic        tone_en,
    output logic [17:0] tone_div
);

    localparam logic [7:0] TEMP_LO = TEMP_HI - TEMP_HYST;
    localparam logic [7:0] HUMI_LO = HUMI_HI - HUMI_HYST;

    typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF} state_t;

    state_t      state_q, state_d;
    logic [24:0] phase_cnt_q, phase_cnt_d;
    logic [17:0] tone_div_q, tone_div_d;
    logic        temp_flag_q, temp_flag_d;
    logic        humi_flag_q, humi_flag_d;
    logic        alarm_q, alarm_d;
    logic        muted_q, muted_d;
    logic        accept, rise, active;

    assign accept = data_valid & checksum_ok;

    // Flags hold in the hysteresis band and on rejected or absent readings.
    always_comb begin
        temp_flag_d = temp_flag_q;
        humi_flag_d = humi_flag_q;
        if (accept) begin
            if (temp_int >= TEMP_HI)
                temp_flag_d = 1'b1;
            else if (temp_int < TEMP_LO)
                temp_flag_d = 1'b0;
            if (humi_int >= HUMI_HI)
                humi_flag_d = 1'b1;
            else if (humi_int < HUMI_LO)
                humi_flag_d = 1'b0;
        end
    end

    assign alarm_d = temp_flag_d | humi_flag_d;
    assign rise    = (~temp_flag_q & temp_flag_d) | (~humi_flag_q & humi_flag_d);

    // A fresh rise re-arms a muted alarm even if mute arrives on the same edge.
    always_comb begin
        muted_d = muted_q;
        if (rise || !alarm_d)
            muted_d = 1'b0;
        else if (mute && alarm_q)
            muted_d = 1'b1;
    end

    assign active = alarm_q & ~muted_q;

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        tone_div_d  = tone_div_q;
        if (!active) begin
            state_d     = IDLE;
            phase_cnt_d = 25'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = BEEP_ON;
                    phase_cnt_d = 25'd0;
                    tone_div_d  = temp_flag_q ? TONE_TEMP : TONE_HUMI;
                end
                BEEP_ON: begin
                    if (phase_cnt_q == TIME_ON) begin
                        state_d     = BEEP_OFF;
                        phase_cnt_d = 25'd0;
                    end else begin
                        phase_cnt_d = phase_cnt_q + 25'd1;
                    end
                end
                BEEP_OFF: begin
                    if (phase_cnt_q == TIME_OFF) begin
                        state_d     = BEEP_ON;
                        phase_cnt_d = 25'd0;
                        tone_div_d  = temp_flag_q ? TONE_TEMP : TONE_HUMI;
                    end else begin
                        phase_cnt_d = phase_cnt_q + 25'd1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    phase_cnt_d = 25'd0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            temp_flag_q <= 1'b0;
            humi_flag_q <= 1'b0;
            alarm_q     <= 1'b0;
            muted_q     <= 1'b0;
            state_q     <= IDLE;
            phase_cnt_q <= 25'd0;
            tone_div_q  <= TONE_TEMP;
        end else begin
            temp_flag_q <= temp_flag_d;
            humi_flag_q <= humi_flag_d;
            alarm_q     <= alarm_d;
            muted_q     <= muted_d;
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            tone_div_q  <= tone_div_d;
        end
    end

    assign alarm    = alarm_q;
    assign tone_en  = (state_q == BEEP_ON);
    assign tone_div = tone_div_q;

endmodule

// File: tb/tb_alarm_tone_ctrl.sv
// Directed bench for alarm_tone_ctrl with a short cadence (5 cycles on, 3 off).
module tb_alarm_tone_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        data_valid = 1'b0;
    logic        checksum_ok = 1'b0;
    logic [7:0]  temp_int = 8'd0;
    logic [7:0]  humi_int = 8'd0;
    logic        mute = 1'b0;
    logic        alarm;
    logic        tone_en;
    logic [17:0] tone_div;

    int errors = 0;
    int checks = 0;

    localparam logic [17:0] DIV_T = 18'd113635;
    localparam logic [17:0] DIV_H = 18'd151514;

    alarm_tone_ctrl #(
        .TIME_ON (25'd4),
        .TIME_OFF(25'd2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_valid (data_valid),
        .checksum_ok(checksum_ok),
        .temp_int   (temp_int),
        .humi_int   (humi_int),
        .mute       (mute),
        .alarm      (alarm),
        .tone_en    (tone_en),
        .tone_div   (tone_div)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic reading(input logic [7:0] t, input logic [7:0] h, input logic ok);
        temp_int    = t;
        humi_int    = h;
        checksum_ok = ok;
        data_valid  = 1'b1;
        step();
        data_valid  = 1'b0;
        checksum_ok = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %0d expected 0", alarm); end
        checks++;
        if (tone_en !== 1'b0) begin errors++; $display("FAIL reset_tone_en: got %0d expected 0", tone_en); end
        checks++;
        if (tone_div !== DIV_T) begin errors++; $display("FAIL reset_tone_div: got %0d expected %0d", tone_div, DIV_T); end
    endtask

    // Leaves the cadence at pattern index 15 (last silent cycle).
    task automatic test_basic();
        reading(8'd31, 8'd50, 1'b1);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL basic_alarm: got %0d expected 1", alarm); end
        checks++;
        if (tone_en !== 1'b0) begin errors++; $display("FAIL basic_tone_latency: got %0d expected 0", tone_en); end
        step();
        checks++;
        if (tone_en !== 1'b1) begin errors++; $display("FAIL basic_tone_en: got %0d expected 1", tone_en); end
        checks++;
        if (tone_div !== DIV_T) begin errors++; $display("FAIL basic_tone_div: got %0d expected %0d", tone_div, DIV_T); end
        for (int i = 1; i < 16; i++) begin
            step();
            checks++;
            if (tone_en !== ((i % 8) < 5)) begin
                errors++;
                $display("FAIL basic_cadence[%0d]: got %0d expected %0d", i, tone_en, (i % 8) < 5);
            end
        end
    endtask

    task automatic test_hysteresis();
        reading(8'd29, 8'd50, 1'b1);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL hyst_hold_alarm: got %0d expected 1", alarm); end
        checks++;
        if (tone_en !== 1'b1) begin errors++; $display("FAIL hyst_hold_tone[16]: got %0d expected 1", tone_en); end
        for (int i = 17; i < 24; i++) begin
            step();
            checks++;
            if (tone_en !== ((i % 8) < 5)) begin
                errors++;
                $display("FAIL hyst_cadence[%0d]: got %0d expected %0d", i, tone_en, (i % 8) < 5);
            end
        end
        reading(8'd27, 8'd50, 1'b1);
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL hyst_clear_alarm: got %0d expected 0", alarm); end
        checks++;
        if (tone_en !== 1'b1) begin errors++; $display("FAIL hyst_clear_tone_lag: got %0d expected 1", tone_en); end
        step();
        checks++;
        if (tone_en !== 1'b0) begin errors++; $display("FAIL hyst_clear_tone: got %0d expected 0", tone_en); end
    endtask

    task automatic test_priority();
        reading(8'd20, 8'd85, 1'b1);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL prio_alarm: got %0d expected 1", alarm); end
        step();
        checks++;
        if (tone_div !== DIV_H) begin errors++; $display("FAIL prio_humi_div: got %0d expected %0d", tone_div, DIV_H); end
        step();
        reading(8'd30, 8'd85, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (tone_en !== 1'b1 || tone_div !== DIV_H) begin
                errors++;
                $display("FAIL prio_div_stable[%0d]: got en=%0d div=%0d expected en=1 div=%0d", i, tone_en, tone_div, DIV_H);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (tone_en !== 1'b0) begin errors++; $display("FAIL prio_off[%0d]: got %0d expected 0", i, tone_en); end
        end
        step();
        checks++;
        if (tone_en !== 1'b1 || tone_div !== DIV_T) begin
            errors++;
            $display("FAIL prio_relatch: got en=%0d div=%0d expected en=1 div=%0d", tone_en, tone_div, DIV_T);
        end
        reading(8'd20, 8'd50, 1'b1);
        step();
        checks++;
        if (alarm !== 1'b0 || tone_en !== 1'b0) begin
            errors++;
            $display("FAIL prio_clear: got alarm=%0d en=%0d expected 0 0", alarm, tone_en);
        end
    endtask

    task automatic test_mute();
        reading(8'd35, 8'd50, 1'b1);
        step();
        step();
        mute = 1'b1;
        step();
        mute = 1'b0;
        checks++;
        if (tone_en !== 1'b1) begin errors++; $display("FAIL mute_lag: got %0d expected 1", tone_en); end
        step();
        checks++;
        if (tone_en !== 1'b0) begin errors++; $display("FAIL mute_silence: got %0d expected 0", tone_en); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (tone_en !== 1'b0 || alarm !== 1'b1) begin
                errors++;
                $display("FAIL mute_hold[%0d]: got en=%0d alarm=%0d expected en=0 alarm=1", i, tone_en, alarm);
            end
        end
        mute = 1'b1;
        reading(8'd35, 8'd85, 1'b1);
        mute = 1'b0;
        step();
        checks++;
        if (tone_en !== 1'b1 || tone_div !== DIV_T) begin
            errors++;
            $display("FAIL mute_rearm: got en=%0d div=%0d expected en=1 div=%0d", tone_en, tone_div, DIV_T);
        end
        reading(8'd20, 8'd50, 1'b1);
        step();
        checks++;
        if (alarm !== 1'b0 || tone_en !== 1'b0) begin
            errors++;
            $display("FAIL mute_clear: got alarm=%0d en=%0d expected 0 0", alarm, tone_en);
        end
    endtask

    task automatic test_checksum();
        reading(8'd40, 8'd50, 1'b0);
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL cksum_alarm: got %0d expected 0", alarm); end
        step();
        checks++;
        if (tone_en !== 1'b0) begin errors++; $display("FAIL cksum_tone: got %0d expected 0", tone_en); end
        mute = 1'b1;
        step();
        mute = 1'b0;
        reading(8'd40, 8'd50, 1'b1);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL cksum_valid_alarm: got %0d expected 1", alarm); end
        step();
        checks++;
        if (tone_en !== 1'b1) begin errors++; $display("FAIL idle_mute_ignored: got %0d expected 1", tone_en); end
        reading(8'd20, 8'd50, 1'b1);
        step();
    endtask

    task automatic test_reset_mid();
        reading(8'd20, 8'd90, 1'b1);
        step();
        step();
        checks++;
        if (tone_en !== 1'b1 || tone_div !== DIV_H) begin
            errors++;
            $display("FAIL rstmid_pre: got en=%0d div=%0d expected en=1 div=%0d", tone_en, tone_div, DIV_H);
        end
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        checks++;
        if (alarm !== 1'b0 || tone_en !== 1'b0 || tone_div !== DIV_T) begin
            errors++;
            $display("FAIL rstmid_outputs: got alarm=%0d en=%0d div=%0d expected 0 0 %0d", alarm, tone_en, tone_div, DIV_T);
        end
        reading(8'd31, 8'd50, 1'b1);
        checks++;
        if (alarm !== 1'b1 || tone_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_restart_alarm: got alarm=%0d en=%0d expected 1 0", alarm, tone_en);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (tone_en !== (i < 5)) begin
                errors++;
                $display("FAIL rstmid_cadence[%0d]: got %0d expected %0d", i, tone_en, i < 5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hysteresis();
        test_priority();
        test_mute();
        test_checksum();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_tone_ctrl.md
# alarm_tone_ctrl

Alarm sequencer between the DHT11 reading path and the buzzer tone generator. It compares each valid temperature/humidity reading against fixed thresholds with hysteresis and raises a latched alarm. It then drives the buzzer stage with an on/off cadence (`tone_en`) and a tone divider count (`tone_div`, same units as the buzzer's 50 MHz note-period counts). A mute input silences an active alarm until conditions change.

## Interface
- `TEMP_HI`, 8'd30: temperature alarm set level (integer °C); constraint `TEMP_HYST < TEMP_HI`.
- `TEMP_HYST`, 8'd2: temperature clear hysteresis; the flag clears when `temp_int < TEMP_HI - TEMP_HYST`.
- `HUMI_HI`, 8'd80: humidity alarm set level (integer %RH); constraint `HUMI_HYST < HUMI_HI`.
- `HUMI_HYST`, 8'd5: humidity clear hysteresis.
- `TIME_ON`, 25'd24999999: tone-on phase length minus 1, in cycles.
- `TIME_OFF`, 25'd24999999: silent phase length minus 1, in cycles.
- `TONE_TEMP`, 18'd113635: divider count for the temperature alarm (LA, 440 Hz).
- `TONE_HUMI`, 18'd151514: divider count for the humidity alarm (MI, 330 Hz).

Ports:
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst`  in  1  synchronous, active-high reset.
- `data_valid`  in  1  one-cycle strobe; a new reading is present.
- `checksum_ok`  in  1  qualifies `data_valid`; when 0 the reading is ignored.
- `temp_int`  in  8  integer part of temperature.
- `humi_int`  in  8  integer part of humidity.
- `mute`  in  1  one-cycle acknowledge pulse.
- `alarm`  out  1  OR of the temperature and humidity flags (registered).
- `tone_en`  out  1  high while the buzzer must sound.
- `tone_div`  out  18  divider count for the buzzer; valid while `tone_en = 1`.

## Operation
- **Reset values:** `temp_flag = 0`, `humi_flag = 0`, `alarm = 0`, `muted = 0`, state = `IDLE`, `phase_cnt = 0`, `tone_en = 0`, `tone_div = TONE_TEMP`.
- **Reading accepted:** `data_valid & checksum_ok`.
  - On an accepted reading, `temp_flag` sets if `temp_int >= TEMP_HI`.
  - It clears if `temp_int < TEMP_HI - TEMP_HYST`.
  - Otherwise it holds its value. `humi_flag` follows the same rules with `HUMI_HI`/`HUMI_HYST`.
  - Readings with `checksum_ok = 0`, and cycles without `data_valid`, leave both flags unchanged.
  - All comparisons are unsigned 8-bit.
- **`alarm`** is `temp_flag | humi_flag`, registered together with the flags.
- **`rise`** is the one-cycle condition where either flag goes from 0 to 1 on an accepted reading.
- **Mute:**
  - `muted` sets on `mute = 1` while `alarm = 1`.
  - `muted` clears when `alarm` becomes 0, or on `rise`.
  - `rise` wins over a simultaneous `mute`.
  - `mute` while `alarm = 0` is ignored.
- **Active condition:** `active = alarm & ~muted`.
- **FSM states:** `IDLE`, `BEEP_ON`, `BEEP_OFF`.
  - `IDLE`: if `active`, go to `BEEP_ON`, reset `phase_cnt` to 0, and latch `tone_div` (`TONE_TEMP` if `temp_flag`, else `TONE_HUMI`).
  - `BEEP_ON`: `phase_cnt` increments; when `phase_cnt == TIME_ON`, go to `BEEP_OFF` with `phase_cnt = 0`.
  - `BEEP_OFF`: `phase_cnt` increments; when `phase_cnt == TIME_OFF`, go to `BEEP_ON` with `phase_cnt = 0` and re-latch `tone_div` under the same priority rule.
  - From any state, `~active` forces `IDLE` with `phase_cnt = 0`. This has priority over the phase-end transitions.
- **`tone_en`** is 1 exactly when state = `BEEP_ON` (decoded from the state register).
- **`tone_div` stability:** it does not change during a `BEEP_ON` phase; a flag change mid-phase takes effect at the next `BEEP_ON` entry.
- **Counter width:** `phase_cnt` is 25 bits and never exceeds the larger of `TIME_ON`/`TIME_OFF`, so no wrap can occur.

## Timing
- Accepted reading sampled at edge k: flags and `alarm` update after edge k.
- The FSM sees the new `active` at edge k+1, so `tone_en` rises after edge k+1 (2-edge latency from the strobe).
- Tone-on lasts `TIME_ON + 1` cycles and silence lasts `TIME_OFF + 1` cycles; the cadence period is `TIME_ON + TIME_OFF + 2`.
- `mute` sampled at edge k: `muted` is set after edge k, and `tone_en` falls after edge k+1.
- A clearing reading at edge k: `alarm` falls after edge k, and `tone_en` falls after edge k+1.
- `sys_rst` asserted mid-cadence: all outputs are at reset values after that edge, and no cadence state is retained.

## Test plan
Bench parameters: `TIME_ON = 4`, `TIME_OFF = 2`, defaults otherwise.

1. Reset, then a valid reading `temp = 31`, `humi = 50` → `alarm = 1` after 1 edge; `tone_en = 1` after 2 edges with `tone_div = 113635`; `tone_en` pattern is 5 cycles high, 3 low, repeating.
2. Hysteresis: while alarmed, `temp = 29` → flags and cadence unchanged; `temp = 27` → `alarm = 0`, `tone_en = 0` one edge later.
3. Priority and latching: `humi = 85` only → `tone_div = 151514`. Then `temp = 30` arrives mid-`BEEP_ON` → `tone_div` stays 151514 until the next `BEEP_ON` entry, then becomes 113635.
4. Mute: pulse `mute` during the alarm → `tone_en = 0` after 2 edges and stays low while `alarm = 1`. A new humidity rise re-arms the cadence; `mute` and `rise` on the same edge → the cadence still starts.
5. Checksum: `data_valid` with `checksum_ok = 0` and `temp = 40` → `alarm` stays 0; `mute` with `alarm = 0` → no effect on a later alarm.
6. Reset mid-`BEEP_ON` → after the reset edge `alarm = 0`, `tone_en = 0`, `tone_div = 113635`; the FSM starts from `IDLE` on the next alarm.
